// File: rtl/cpu_instr_sequencer.sv
// Instruction fetch/issue stage for the 4-bit-address CPU core: a loadable
// program memory stepped by a program counter, driving registered opcode/address/myinput.
module cpu_instr_sequencer #(
    parameter int          N       = 4,
    parameter int          W       = 8,
    parameter logic [3:0]  IDLE_OP = 4'b0110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             prog_we,
    input  logic [N-1:0]     prog_addr,
    input  logic [W+7:0]     prog_data,
    input  logic             start,
    input  logic             hold,
    output logic [3:0]       opcode,
    output logic [N-1:0]     address,
    output logic [W-1:0]     myinput,
    output logic             issue_valid,
    output logic [N-1:0]     pc,
    output logic             busy,
    output logic             halted,
    output logic             done,
    output logic [7:0]       icount
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam int            DEPTH    = 2 ** N;
    localparam logic [3:0]    HLT_OP   = 4'b1111;
    localparam logic [W+7:0]  HLT_WORD = {HLT_OP, 4'b0000, {W{1'b0}}};
    localparam logic [N-1:0]  PC_LAST  = '1;
    localparam logic [N-1:0]  PC_ONE   = {{(N-1){1'b0}}, 1'b1};

    state_t         state;
    logic [W+7:0]   mem [DEPTH];
    logic [W+7:0]   fetch_word;

    assign fetch_word = mem[pc];
    assign busy       = (state == RUN);
    assign halted     = (state == HALT);

    // NOTE: the program memory is reset to HLT words so an unloaded program
    // halts at once; this forces it into flops rather than a RAM macro.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            pc          <= '0;
            icount      <= '0;
            opcode      <= IDLE_OP;
            address     <= '0;
            myinput     <= '0;
            issue_valid <= 1'b0;
            done        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= HLT_WORD;
            end
        end else begin
            // NOTE: non-blocking throughout, so these defaults are simply
            // overridden by a later assignment in the same edge when an issue occurs.
            opcode      <= IDLE_OP;
            address     <= '0;
            myinput     <= '0;
            issue_valid <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE, HALT: begin
                    if (prog_we) begin
                        mem[prog_addr] <= prog_data;
                    end
                    if (start) begin
                        pc     <= '0;
                        icount <= '0;
                        state  <= RUN;
                    end
                end

                RUN: begin
                    if (!hold) begin
                        opcode      <= fetch_word[W+7:W+4];
                        address     <= fetch_word[W +: N];
                        myinput     <= fetch_word[W-1:0];
                        issue_valid <= 1'b1;
                        if (icount != 8'hFF) begin
                            icount <= icount + 8'd1;
                        end
                        // Stop on HLT or at the last entry; the pc never wraps.
                        if (fetch_word[W+7:W+4] == HLT_OP || pc == PC_LAST) begin
                            state <= HALT;
                            done  <= 1'b1;
                        end else begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_instr_sequencer.md
# cpu_instr_sequencer

Instruction fetch/issue stage that sits directly upstream of the 4-bit-address CPU core. It holds a small program memory, loaded over a write port, and steps a program counter through it once started. Each cycle it drives the core's `opcode`, `address` and `myinput` inputs from a registered instruction word. It stops on the HLT opcode (4'b1111) or at the end of memory, and replaces the external test-bench drive of the core with a self-contained sequencer.

## Interface
- `N`, 4, address width; program depth is 2^N entries.
- `W`, 8, operand/data width.
- `IDLE_OP`, 4'b0110, opcode driven whenever no instruction is issued (Output: does not modify core memory).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, **asynchronous, active-low**.
- `prog_we` input 1: program write strobe.
- `prog_addr` input N: program write address.
- `prog_data` input 8+W: instruction word. Fields: [W+7:W+4] opcode, [W+3:W] address (low N bits used), [W-1:0] operand.
- `start` input 1: begin execution from entry 0.
- `hold` input 1: stall issue for this cycle.
- `opcode` output 4: to core `opcode`.
- `address` output N: to core `address`.
- `myinput` output W: to core `myinput`.
- `issue_valid` output 1: high when outputs carry a real fetched instruction this cycle.
- `pc` output N: next entry to be fetched.
- `busy` output 1: state == RUN.
- `halted` output 1: state == HALT.
- `done` output 1: one-cycle pulse on entry to HALT.
- `icount` output 8: instructions issued since last start, saturating at 255.

## Operation
- States: IDLE, RUN, HALT.
- Reset (rst=0), applied immediately regardless of clock:
  - state=IDLE, pc=0, icount=0.
  - opcode=IDLE_OP, address=0, myinput=0, issue_valid=0, done=0.
  - Every program entry is set to {4'b1111, 4'b0, 8'h00}, so an unloaded program halts at once.
- Program writes:
  - Accepted in IDLE or HALT on any edge with prog_we=1: mem[prog_addr] <= prog_data.
  - Silently ignored in RUN.
- IDLE/HALT behaviour:
  - start=1 → pc<=0, icount<=0, state<=RUN.
  - Outputs hold IDLE_OP/0/0 with issue_valid=0.
- RUN, hold=0, each edge:
  - {opcode,address,myinput} <= mem[pc]; issue_valid<=1; icount<=sat(icount+1).
  - If the fetched opcode==4'b1111: the HLT is issued (valid) this cycle, state<=HALT, done<=1, pc unchanged.
  - Else if pc==2^N-1: state<=HALT, done<=1, pc stays 2^N-1 (no wrap).
  - Else pc<=pc+1.
- RUN, hold=1: pc and icount frozen; outputs <= IDLE_OP/0/0, issue_valid<=0.
- start is ignored in RUN.
- prog_we and start on the same IDLE edge: the write lands, and the first fetch (next edge) sees the new data.
- Output registers always return to IDLE_OP/0/0, valid=0, on the edge after an issue unless another issue occurs.

## Timing
- All outputs registered; no combinational input→output paths.
- start sampled at edge k; first instruction (mem[0]) appears on outputs after edge k+1, with issue_valid=1 for that cycle.
- Throughput is one instruction per cycle with hold low; there are no bubbles between entries.
- done is high for exactly the cycle following the edge that issued the final instruction; halted rises on that same edge.
- hold takes effect on the edge where it is sampled; the issue resumes at the same pc on the first edge with hold=0.
- An rst assertion mid-RUN drops the outputs to their idle values immediately, without waiting for clk, and clears the program to HLT words.

## Test plan
- **Reset:** drive rst=0 mid-cycle → outputs are immediately IDLE_OP(4'b0110)/0/0, issue_valid=0, busy=0, halted=0, pc=0. After release, start → one HLT issued, halted=1, icount=1.
- **Short program:** load mem[0]=0x5_0_3C (Input 0x3C to addr 0), mem[1]=0x0_0_04 (Add), mem[2]=0xF_0_00, then start at edge k.
  - Edges k+1..k+3 issue 0x5/0/0x3C, 0x0/0/0x04, 0xF/0/0x00, each with valid=1.
  - done pulses after k+3; icount=3; next cycle shows IDLE_OP with valid=0.
- **Stall:** same program with hold=1 for 2 cycles after the first issue → two cycles of IDLE_OP with valid=0 and pc=1 frozen, then mem[1] issued. icount=3 at HALT.
- **No HLT:** 16 entries of opcode 4'b0110 → 16 consecutive valid issues, halt with pc=15 and icount=16, no wrap to entry 0.
- **Write during RUN:** prog_we to entry 2 with 0x1_0_FF while running the short program → entry 2 is still issued as the HLT word. After HALT, the same write succeeds and restarting issues 0x1/0/0xFF.
- **Async reset mid-run:** rst=0 during the second issue → outputs are idle before the next edge. After release, start issues a single HLT, confirming the program memory was cleared.
